// File: rtl/drive_cmd_arbiter_pkg.sv
// Shared definitions for the drive command arbiter: direction-control codes,
// source indices, FSM state encoding and a small one-hot helper.
package drive_cmd_arbiter_pkg;

    localparam int unsigned NUM_SRC = 3;
    localparam int unsigned CMD_W   = 4;
    localparam int unsigned SRC_W   = 2;

    typedef logic [CMD_W-1:0] dir_cmd_t;
    typedef logic [SRC_W-1:0] src_idx_t;

    // Direction-control command codes understood by the drive block
    localparam dir_cmd_t DC_PROCEED = 4'b0000;
    localparam dir_cmd_t DC_LEFT    = 4'b0001;
    localparam dir_cmd_t DC_RIGHT   = 4'b0010;
    localparam dir_cmd_t DC_UTURN   = 4'b0100;
    localparam dir_cmd_t DC_STOP    = 4'b1000;

    localparam dir_cmd_t IDLE_CMD_DEFAULT = DC_PROCEED;

    // Source indices, lower index = higher priority
    localparam src_idx_t SRC_COL  = 2'd0;
    localparam src_idx_t SRC_NAV  = 2'd1;
    localparam src_idx_t SRC_LINE = 2'd2;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_GAP   = 2'd2
    } arb_state_e;

    // One-hot grant vector for a source index
    function automatic logic [NUM_SRC-1:0] src_onehot(input src_idx_t s);
        return NUM_SRC'(1) << s;
    endfunction

endpackage

// File: rtl/drive_cmd_arbiter_hold_timer.sv
// Grant-length counter for the drive command arbiter.
// Ports:
//   i_clk         system clock
//   i_rst         asynchronous reset, active low
//   i_clear       restart the count at 0 on the next edge (new grant / no grant)
//   o_min_met_c   count has reached MIN_HOLD-1 (release allowed this cycle)
//   o_wd_expire_c count equals MAX_HOLD-1 (watchdog revokes this cycle)
module drive_cmd_arbiter_hold_timer
    import drive_cmd_arbiter_pkg::*;
#(
    parameter int unsigned MIN_HOLD = 1_000_000,
    parameter int unsigned MAX_HOLD = 50_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    output logic o_min_met_c,
    output logic o_wd_expire_c
);

    localparam int unsigned CNT_W  = $clog2(MAX_HOLD + 1);
    localparam int unsigned MIN_TH = (MIN_HOLD == 0) ? 0 : MIN_HOLD - 1;
    localparam int unsigned WD_TH  = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

    logic [CNT_W-1:0] r_hold_cnt;
    logic             w_sat;

    assign w_sat         = (r_hold_cnt == CNT_W'(MAX_HOLD));
    assign o_min_met_c   = (r_hold_cnt >= CNT_W'(MIN_TH));
    assign o_wd_expire_c = (r_hold_cnt == CNT_W'(WD_TH));

    // Counts grant cycles, holding at MAX_HOLD (only a safety grant gets there)
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_hold_cnt <= '0;
        end else if (i_clear) begin
            r_hold_cnt <= '0;
        end else if (!w_sat) begin
            r_hold_cnt <= r_hold_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/drive_cmd_arbiter.sv
// Sole owner of the 4-bit direction-control bus into the drive block.
// Fixed-priority arbitration of three sources (0 safety, 1 navigator, 2 line
// follower) with minimum hold, grant watchdog and a dead gap between owners.
// Ports:
//   i_clk, i_rst (async, active low)
//   i_req[2:0]        level request per source, bit 0 highest priority
//   i_cmd0..i_cmd2    per-source direction commands
//   o_gnt[2:0]        registered one-hot grant
//   o_dir_control     registered command to the drive block
//   o_busy            registered, high in GRANT or GAP
//   o_timeout         registered one-cycle pulse on watchdog revoke
module drive_cmd_arbiter
    import drive_cmd_arbiter_pkg::*;
#(
    parameter int unsigned MIN_HOLD   = 1_000_000,
    parameter int unsigned MAX_HOLD   = 50_000_000,
    parameter int unsigned GAP_CYCLES = 1000,
    parameter logic [CMD_W-1:0] IDLE_CMD = IDLE_CMD_DEFAULT
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [CMD_W-1:0]   i_cmd0,
    input  logic [CMD_W-1:0]   i_cmd1,
    input  logic [CMD_W-1:0]   i_cmd2,
    output logic [NUM_SRC-1:0] o_gnt,
    output logic [CMD_W-1:0]   o_dir_control,
    output logic               o_busy,
    output logic               o_timeout
);

    localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GAP_LAST = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;
    // With no gap configured a non-safety release lands straight in IDLE
    localparam arb_state_e  REL_STATE = (GAP_CYCLES == 0) ? ARB_IDLE : ARB_GAP;

    arb_state_e         r_state, w_state_nxt;
    src_idx_t           r_owner, w_owner_nxt;
    logic [GAP_W-1:0]   r_gap_cnt, w_gap_cnt_nxt;
    logic [NUM_SRC-1:0] r_lockout, w_lockout_nxt;
    logic [NUM_SRC-1:0] r_gnt, w_gnt_nxt;
    dir_cmd_t           r_dir, w_dir_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_timeout, w_timeout_nxt;

    logic [NUM_SRC-1:0] w_avail;
    logic               w_win_valid;
    src_idx_t           w_win;
    logic               w_owner_req;
    logic               w_preempt;
    logic               w_new_grant;
    logic               w_wd_fire;
    logic               w_hold_clear;
    logic               w_min_met;
    logic               w_wd_expire;

    function automatic dir_cmd_t pick_cmd(input src_idx_t s, input dir_cmd_t c0,
                                          input dir_cmd_t c1, input dir_cmd_t c2);
        case (s)
            SRC_COL: return c0;
            SRC_NAV: return c1;
            default: return c2;
        endcase
    endfunction

    function automatic logic pick_req(input src_idx_t s, input logic [NUM_SRC-1:0] r);
        case (s)
            SRC_COL: return r[0];
            SRC_NAV: return r[1];
            default: return r[2];
        endcase
    endfunction

    drive_cmd_arbiter_hold_timer #(
        .MIN_HOLD (MIN_HOLD),
        .MAX_HOLD (MAX_HOLD)
    ) u_hold_timer (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_clear       (w_hold_clear),
        .o_min_met_c   (w_min_met),
        .o_wd_expire_c (w_wd_expire)
    );

    // Fixed-priority pick among requesters that are not locked out
    always_comb begin : p_prio
        w_avail     = i_req & ~r_lockout;
        w_win_valid = |w_avail;
        w_win       = SRC_LINE;
        if (w_avail[0]) begin
            w_win = SRC_COL;
        end else if (w_avail[1]) begin
            w_win = SRC_NAV;
        end
    end

    assign w_owner_req = pick_req(r_owner, i_req);
    assign w_preempt   = (r_state == ARB_GRANT) && (r_owner != SRC_COL) && i_req[0];

    // State register plus registered outputs
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state   <= ARB_IDLE;
            r_owner   <= SRC_COL;
            r_gap_cnt <= '0;
            r_lockout <= '0;
            r_gnt     <= '0;
            r_dir     <= IDLE_CMD;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_lockout <= w_lockout_nxt;
            r_gnt     <= w_gnt_nxt;
            r_dir     <= w_dir_nxt;
            r_busy    <= w_busy_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // Next state; priority in GRANT is preempt > release > watchdog
    always_comb begin : p_next
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_gap_cnt_nxt = r_gap_cnt;
        w_new_grant   = 1'b0;
        w_wd_fire     = 1'b0;
        // A lockout bit is dropped once its requester lets go
        w_lockout_nxt = r_lockout & i_req;
        case (r_state)
            ARB_IDLE: begin
                if (w_win_valid) begin
                    w_state_nxt = ARB_GRANT;
                    w_owner_nxt = w_win;
                    w_new_grant = 1'b1;
                end
            end
            ARB_GRANT: begin
                if (w_preempt) begin
                    w_owner_nxt = SRC_COL;
                    w_new_grant = 1'b1;
                end else if (r_owner == SRC_COL) begin
                    if (!i_req[0]) begin
                        w_state_nxt = ARB_IDLE;
                    end
                end else if (!w_owner_req && w_min_met) begin
                    w_state_nxt   = REL_STATE;
                    w_gap_cnt_nxt = '0;
                end else if (w_wd_expire) begin
                    w_state_nxt   = REL_STATE;
                    w_gap_cnt_nxt = '0;
                    w_wd_fire     = 1'b1;
                    w_lockout_nxt = w_lockout_nxt | src_onehot(r_owner);
                end
            end
            ARB_GAP: begin
                if (i_req[0]) begin
                    w_state_nxt = ARB_GRANT;
                    w_owner_nxt = SRC_COL;
                    w_new_grant = 1'b1;
                end else if (r_gap_cnt == GAP_W'(GAP_LAST)) begin
                    w_state_nxt = ARB_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    // Next output values; the grant owner's command is frozen while its req is low
    always_comb begin : p_out
        w_gnt_nxt     = '0;
        w_dir_nxt     = IDLE_CMD;
        w_busy_nxt    = (w_state_nxt != ARB_IDLE);
        w_timeout_nxt = w_wd_fire;
        w_hold_clear  = w_new_grant || (w_state_nxt != ARB_GRANT);
        if (w_state_nxt == ARB_GRANT) begin
            w_gnt_nxt = src_onehot(w_owner_nxt);
            if (pick_req(w_owner_nxt, i_req)) begin
                w_dir_nxt = pick_cmd(w_owner_nxt, i_cmd0, i_cmd1, i_cmd2);
            end else begin
                w_dir_nxt = r_dir;
            end
        end
    end

    assign o_gnt         = r_gnt;
    assign o_dir_control = r_dir;
    assign o_busy        = r_busy;
    assign o_timeout     = r_timeout;

endmodule

// File: tb/tb_drive_cmd_arbiter.sv
// Self-checking bench for drive_cmd_arbiter (MIN_HOLD=4, MAX_HOLD=20, GAP_CYCLES=2).
module tb_drive_cmd_arbiter;

    localparam logic [3:0] C0 = 4'b1100;
    localparam logic [3:0] C1 = 4'b0101;
    localparam logic [3:0] C2 = 4'b0011;
    localparam logic [3:0] IC = 4'b0000;
    localparam int NVEC = 30;

    typedef struct {
        logic [2:0] req;
        logic [3:0] c0;
        logic [3:0] c1;
        logic [3:0] c2;
        logic [2:0] gnt;
        logic [3:0] dir;
        logic       busy;
        logic       to;
    } vec_t;

    typedef struct {
        logic [2:0] gnt;
        logic [3:0] dir;
        logic       busy;
        logic       to;
        string      nm;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic [3:0] cmd0, cmd1, cmd2;
    logic [2:0] gnt;
    logic [3:0] dir;
    logic       busy;
    logic       timeout;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    vec_t tbl[NVEC];

    always #5 clk = ~clk;

    drive_cmd_arbiter #(
        .MIN_HOLD   (4),
        .MAX_HOLD   (20),
        .GAP_CYCLES (2),
        .IDLE_CMD   (4'b0000)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req         (req),
        .i_cmd0        (cmd0),
        .i_cmd1        (cmd1),
        .i_cmd2        (cmd2),
        .o_gnt         (gnt),
        .o_dir_control (dir),
        .o_busy        (busy),
        .o_timeout     (timeout)
    );

    task automatic push_exp(input logic [2:0] eg, input logic [3:0] ed,
                            input logic eb, input logic et, input string nm);
        exp_t e;
        e.gnt = eg; e.dir = ed; e.busy = eb; e.to = et; e.nm = nm;
        sb_q.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: no expected entry for gnt=%b dir=%b", gnt, dir);
            return;
        end
        e = sb_q.pop_front();
        if (gnt !== e.gnt || dir !== e.dir || busy !== e.busy || timeout !== e.to) begin
            n_fail++;
            $display("FAIL %s: got gnt=%b dir=%b busy=%b timeout=%b, want gnt=%b dir=%b busy=%b timeout=%b",
                     e.nm, gnt, dir, busy, timeout, e.gnt, e.dir, e.busy, e.to);
        end
    endtask

    // Drive one cycle of inputs, record the expectation, compare after the edge
    task automatic step(input logic [2:0] r, input logic [3:0] c0, input logic [3:0] c1,
                        input logic [3:0] c2, input logic [2:0] eg, input logic [3:0] ed,
                        input logic eb, input logic et, input string nm);
        @(negedge clk);
        req = r; cmd0 = c0; cmd1 = c1; cmd2 = c2;
        push_exp(eg, ed, eb, et, nm);
        @(posedge clk);
        #1;
        check_pop();
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: bench did not finish in time");
        $fatal(1, "time limit");
    end

    initial begin
        //          req     c0       c1       c2       gnt     dir      busy  to
        tbl[0]  = '{3'b110, C0,      C1,      C2,      3'b010, C1,      1'b1, 1'b0}; // nav beats line
        tbl[1]  = '{3'b110, C0,      4'b0110, C2,      3'b010, 4'b0110, 1'b1, 1'b0}; // tracks cmd1
        tbl[2]  = '{3'b100, C0,      4'b1111, C2,      3'b010, 4'b0110, 1'b1, 1'b0}; // early drop: frozen
        tbl[3]  = '{3'b110, C0,      4'b1001, C2,      3'b010, 4'b1001, 1'b1, 1'b0}; // re-assert resumes
        tbl[4]  = '{3'b100, C0,      4'b1001, C2,      3'b000, IC,      1'b1, 1'b0}; // release at hold 3
        tbl[5]  = '{3'b100, C0,      C1,      C2,      3'b000, IC,      1'b1, 1'b0}; // gap
        tbl[6]  = '{3'b100, C0,      C1,      C2,      3'b000, IC,      1'b0, 1'b0}; // idle
        tbl[7]  = '{3'b100, C0,      C1,      C2,      3'b100, C2,      1'b1, 1'b0}; // line granted
        tbl[8]  = '{3'b100, C0,      C1,      C2,      3'b100, C2,      1'b1, 1'b0};
        tbl[9]  = '{3'b010, C0,      C1,      4'b1110, 3'b100, C2,      1'b1, 1'b0}; // drop at hold 1
        tbl[10] = '{3'b010, C0,      C1,      4'b1110, 3'b100, C2,      1'b1, 1'b0};
        tbl[11] = '{3'b010, C0,      C1,      4'b1110, 3'b000, IC,      1'b1, 1'b0}; // release at hold 3
        tbl[12] = '{3'b010, C0,      C1,      C2,      3'b000, IC,      1'b1, 1'b0};
        tbl[13] = '{3'b010, C0,      C1,      C2,      3'b000, IC,      1'b0, 1'b0};
        tbl[14] = '{3'b010, C0,      C1,      C2,      3'b010, C1,      1'b1, 1'b0}; // nav re-granted
        tbl[15] = '{3'b010, C0,      C1,      C2,      3'b010, C1,      1'b1, 1'b0};
        tbl[16] = '{3'b010, C0,      C1,      C2,      3'b010, C1,      1'b1, 1'b0};
        tbl[17] = '{3'b011, 4'b1100, C1,      C2,      3'b001, 4'b1100, 1'b1, 1'b0}; // preempt at hold 2
        tbl[18] = '{3'b011, 4'b1010, C1,      C2,      3'b001, 4'b1010, 1'b1, 1'b0};
        tbl[19] = '{3'b010, C0,      C1,      C2,      3'b000, IC,      1'b0, 1'b0}; // safety release: no gap
        tbl[20] = '{3'b010, C0,      C1,      C2,      3'b010, C1,      1'b1, 1'b0};
        tbl[21] = '{3'b000, C0,      C1,      C2,      3'b010, C1,      1'b1, 1'b0};
        tbl[22] = '{3'b000, C0,      C1,      C2,      3'b010, C1,      1'b1, 1'b0};
        tbl[23] = '{3'b000, C0,      C1,      C2,      3'b010, C1,      1'b1, 1'b0};
        tbl[24] = '{3'b000, C0,      C1,      C2,      3'b000, IC,      1'b1, 1'b0};
        tbl[25] = '{3'b001, 4'b0111, C1,      C2,      3'b001, 4'b0111, 1'b1, 1'b0}; // safety aborts gap
        tbl[26] = '{3'b000, C0,      C1,      C2,      3'b000, IC,      1'b0, 1'b0};
        tbl[27] = '{3'b000, C0,      C1,      C2,      3'b000, IC,      1'b0, 1'b0};
        tbl[28] = '{3'b111, C0,      C1,      C2,      3'b001, C0,      1'b1, 1'b0}; // all request
        tbl[29] = '{3'b000, C0,      C1,      C2,      3'b000, IC,      1'b0, 1'b0};

        rst = 1'b0; req = '0; cmd0 = C0; cmd1 = C1; cmd2 = C2;
        repeat (2) @(posedge clk);
        #1;
        push_exp(3'b000, IC, 1'b0, 1'b0, "reset_state");
        check_pop();
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            step(tbl[i].req, tbl[i].c0, tbl[i].c1, tbl[i].c2,
                 tbl[i].gnt, tbl[i].dir, tbl[i].busy, tbl[i].to, $sformatf("vec%0d", i));
        end

        // Watchdog: line held past MAX_HOLD, revoked with one timeout pulse
        step(3'b100, C0, C1, C2, 3'b100, C2, 1'b1, 1'b0, "wd_grant");
        for (int i = 0; i < 19; i++) begin
            step(3'b110, C0, C1, C2, 3'b100, C2, 1'b1, 1'b0, $sformatf("wd_hold%0d", i));
        end
        step(3'b110, C0, C1, C2, 3'b000, IC, 1'b1, 1'b1, "wd_revoke");
        step(3'b110, C0, C1, C2, 3'b000, IC, 1'b1, 1'b0, "wd_pulse_end");
        step(3'b110, C0, C1, C2, 3'b000, IC, 1'b0, 1'b0, "wd_idle");
        step(3'b110, C0, C1, C2, 3'b010, C1, 1'b1, 1'b0, "wd_nav_after_gap");
        for (int i = 0; i < 3; i++) begin
            step(3'b100, C0, C1, C2, 3'b010, C1, 1'b1, 1'b0, $sformatf("wd_nav_hold%0d", i));
        end
        step(3'b100, C0, C1, C2, 3'b000, IC, 1'b1, 1'b0, "wd_nav_release");
        step(3'b100, C0, C1, C2, 3'b000, IC, 1'b1, 1'b0, "wd_gap2");
        step(3'b100, C0, C1, C2, 3'b000, IC, 1'b0, 1'b0, "wd_idle2");
        step(3'b100, C0, C1, C2, 3'b000, IC, 1'b0, 1'b0, "wd_locked_out");
        step(3'b000, C0, C1, C2, 3'b000, IC, 1'b0, 1'b0, "wd_req_toggle");
        step(3'b100, C0, C1, C2, 3'b100, C2, 1'b1, 1'b0, "wd_unlocked");

        // Preempt on the watchdog cycle: safety wins, no pulse, no lockout
        for (int i = 0; i < 19; i++) begin
            step(3'b100, C0, C1, C2, 3'b100, C2, 1'b1, 1'b0, $sformatf("pw_hold%0d", i));
        end
        step(3'b101, C0, C1, C2, 3'b001, C0, 1'b1, 1'b0, "pw_preempt");
        step(3'b100, C0, C1, C2, 3'b000, IC, 1'b0, 1'b0, "pw_safety_release");
        step(3'b100, C0, C1, C2, 3'b100, C2, 1'b1, 1'b0, "pw_line_not_locked");

        // Release on the watchdog cycle: plain release, no pulse
        for (int i = 0; i < 19; i++) begin
            step(3'b100, C0, C1, C2, 3'b100, C2, 1'b1, 1'b0, $sformatf("rw_hold%0d", i));
        end
        step(3'b000, C0, C1, C2, 3'b000, IC, 1'b1, 1'b0, "rw_release");
        step(3'b000, C0, C1, C2, 3'b000, IC, 1'b1, 1'b0, "rw_gap");
        step(3'b000, C0, C1, C2, 3'b000, IC, 1'b0, 1'b0, "rw_idle");
        step(3'b100, C0, C1, C2, 3'b100, C2, 1'b1, 1'b0, "rw_regrant");

        // Asynchronous reset in the middle of a grant
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        #1;
        push_exp(3'b000, IC, 1'b0, 1'b0, "reset_mid_grant");
        check_pop();
        @(negedge clk);
        rst = 1'b1;
        step(3'b100, C0, C1, C2, 3'b100, C2, 1'b1, 1'b0, "after_reset_grant");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
